audio_framer: RTL and testbench

AUDIO_FRAMER -- requirements
Module: audio_framer

---
 rtl/audio_framer.sv | 164 ++++++++++++++++
 tb/tb_audio_framer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/audio_framer.sv
// Overlapping-frame collector for an FFT front end: buffers samples, cuts FRAME_LEN
// frames every HOP samples, applies a triangular window and streams them out.
module audio_framer #(
    parameter int FRAME_LEN = 512,
    parameter int HOP       = 256
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        enable_in,
    input  logic [15:0] sample_in,
    input  logic        sample_valid_in,
    output logic [31:0] fft_data_out,
    output logic        fft_valid_out,
    output logic        fft_last_out,
    input  logic        fft_ready_in,
    output logic        overrun_out
);
    localparam int LOG2N = $clog2(FRAME_LEN);
    localparam int AW    = LOG2N + 1;
    localparam int PW    = 17 + LOG2N;
    localparam logic [LOG2N-1:0] LAST_N = LOG2N'(FRAME_LEN - 1);
    localparam logic [LOG2N-1:0] HALF   = LOG2N'(FRAME_LEN / 2);
    localparam logic [LOG2N-1:0] HOP_M1 = LOG2N'(HOP - 1);

    typedef enum logic [1:0] {FILL, WAIT, STREAM} state_t;

    state_t            state_q;
    logic [15:0]       mem_q [2*FRAME_LEN];
    logic [AW-1:0]     wr_ptr_q, base_q, pend_base_q;
    logic [LOG2N-1:0]  fill_cnt_q, hop_cnt_q, rd_n_q, s1_n_q;
    logic              primed_q, pend_q, issue_act_q, overrun_q;
    logic [2:0]        vld_pipe_q;
    logic signed [15:0] s1_smp_q, s2_data_q, data_q;
    logic              s2_last_q, last_q;

    logic              accept, trig, adv, issue, last_hs;
    logic [AW-1:0]     trig_base, rd_addr;
    logic [LOG2N-1:0]  coef;
    logic signed [PW-1:0] prod, shifted;
    logic signed [15:0] win_d;

    always_comb begin
        accept    = enable_in & sample_valid_in;
        trig      = accept & (primed_q ? (hop_cnt_q == HOP_M1) : (fill_cnt_q == LAST_N));
        trig_base = wr_ptr_q - AW'(FRAME_LEN - 1);
        // Whole read pipeline advances together; only a stalled output register holds it.
        adv       = ~vld_pipe_q[2] | fft_ready_in;
        issue     = adv & issue_act_q;
        last_hs   = vld_pipe_q[2] & fft_ready_in & last_q;
        rd_addr   = base_q + AW'(rd_n_q);
        coef      = (s1_n_q < HALF) ? s1_n_q : (LAST_N - s1_n_q);
        prod      = $signed(s1_smp_q) * $signed({1'b0, coef});
        shifted   = prod >>> (LOG2N - 1);
        win_d     = shifted[15:0];
    end

    // Sample storage and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk_in) begin
        if (accept) mem_q[wr_ptr_q] <= sample_in;
        if (issue)  s1_smp_q <= $signed(mem_q[rd_addr]);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            pend_base_q <= '0;
            fill_cnt_q  <= '0;
            hop_cnt_q   <= '0;
            rd_n_q      <= '0;
            primed_q    <= 1'b0;
            pend_q      <= 1'b0;
            issue_act_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (!enable_in) begin
                wr_ptr_q   <= '0;
                fill_cnt_q <= '0;
                hop_cnt_q  <= '0;
                primed_q   <= 1'b0;
            end else if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (trig) begin
                    fill_cnt_q <= '0;
                    hop_cnt_q  <= '0;
                    primed_q   <= 1'b1;
                end else if (primed_q) begin
                    hop_cnt_q  <= hop_cnt_q + 1'b1;
                end else begin
                    fill_cnt_q <= fill_cnt_q + 1'b1;
                end
            end

            if (issue) begin
                rd_n_q <= rd_n_q + 1'b1;
                if (rd_n_q == LAST_N) issue_act_q <= 1'b0;
            end

            case (state_q)
                FILL, WAIT: begin
                    if (trig) begin
                        state_q     <= STREAM;
                        base_q      <= trig_base;
                        rd_n_q      <= '0;
                        issue_act_q <= 1'b1;
                    end else if (!enable_in) begin
                        state_q <= FILL;
                    end
                end
                default: begin
                    if (last_hs) begin
                        if (pend_q && enable_in) begin
                            base_q      <= pend_base_q;
                            rd_n_q      <= '0;
                            issue_act_q <= 1'b1;
                            pend_q      <= trig;
                            if (trig) pend_base_q <= trig_base;
                        end else if (trig) begin
                            base_q      <= trig_base;
                            rd_n_q      <= '0;
                            issue_act_q <= 1'b1;
                        end else begin
                            pend_q  <= 1'b0;
                            state_q <= (enable_in && primed_q) ? WAIT : FILL;
                        end
                    end else if (trig) begin
                        if (pend_q) overrun_q <= 1'b1;
                        else begin
                            pend_q      <= 1'b1;
                            pend_base_q <= trig_base;
                        end
                    end
                    if (!enable_in) pend_q <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: [0] buffer read, [1] window multiply, [2] output register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            vld_pipe_q <= '0;
            s1_n_q     <= '0;
            s2_data_q  <= '0;
            s2_last_q  <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
        end else if (adv) begin
            vld_pipe_q <= {vld_pipe_q[1:0], issue};
            s1_n_q     <= rd_n_q;
            s2_data_q  <= win_d;
            s2_last_q  <= (s1_n_q == LAST_N);
            data_q     <= s2_data_q;
            last_q     <= vld_pipe_q[1] & s2_last_q;
        end
    end

    assign fft_data_out  = {16'h0000, data_q};
    assign fft_valid_out = vld_pipe_q[2];
    assign fft_last_out  = last_q;
    assign overrun_out   = overrun_q;

endmodule

// File: tb/tb_audio_framer.sv
// Directed bench for audio_framer at FRAME_LEN=8, HOP=4 with hand-computed windowed frames.
module tb_audio_framer;
    localparam int N = 8;
    localparam int H = 4;

    typedef logic signed [15:0] frame_t [N];

    logic        clk_in = 1'b0;
    logic        rst_in, enable_in, sample_valid_in, fft_ready_in;
    logic [15:0] sample_in;
    logic [31:0] fft_data_out;
    logic        fft_valid_out, fft_last_out, overrun_out;
    int          total = 0;
    int          passed = 0;

    always #5 clk_in = ~clk_in;

    audio_framer #(.FRAME_LEN(N), .HOP(H)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .sample_in(sample_in), .sample_valid_in(sample_valid_in),
        .fft_data_out(fft_data_out), .fft_valid_out(fft_valid_out),
        .fft_last_out(fft_last_out), .fft_ready_in(fft_ready_in),
        .overrun_out(overrun_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h required=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        sample_in       = v;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
    endtask

    task automatic restart();
        enable_in = 1'b0;
        tick();
        enable_in = 1'b1;
    endtask

    task automatic stream_check(input frame_t e, input bit rnd, input string tag);
        int idx = 0;
        int budget = 0;
        while (idx < N && budget < 300) begin
            if (fft_valid_out) begin
                chk({tag, "_data"}, fft_data_out, {16'h0000, e[idx]});
                chk({tag, "_last"}, {31'd0, fft_last_out}, {31'd0, (idx == N-1)});
                fft_ready_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (fft_ready_in) idx++;
            end
            tick();
            budget++;
        end
        chk({tag, "_beats"}, idx, N);
        chk({tag, "_idle"}, {31'd0, fft_valid_out}, 32'd0);
        fft_ready_in = 1'b1;
    endtask

    initial begin
        frame_t f30 = '{0, 25, 50, 75, 75, 50, 25, 0};
        frame_t f31a = '{0, 0, 1, 3, 3, 3, 1, 0};
        frame_t f31b = '{0, 1, 3, 6, 6, 5, 2, 0};
        frame_t f32 = '{0, -26, -51, -76, -76, -51, -26, 0};
        int beats, lasts, seen;
        bit lastpos_ok;

        rst_in = 1'b1; enable_in = 1'b0; sample_valid_in = 1'b0;
        sample_in = '0; fft_ready_in = 1'b1;
        #2 rst_in = 1'b0;
        #1;
        chk("rst_valid", {31'd0, fft_valid_out}, 32'd0);
        chk("rst_last", {31'd0, fft_last_out}, 32'd0);
        chk("rst_data", fft_data_out, 32'd0);
        chk("rst_ovr", {31'd0, overrun_out}, 32'd0);
        tick(); tick();
        rst_in = 1'b1;
        enable_in = 1'b1;

        // Constant 100 frame and first-beat latency
        for (int i = 0; i < N; i++) send(16'd100);
        chk("r030_lat0", {31'd0, fft_valid_out}, 32'd0);
        tick();
        chk("r030_lat1", {31'd0, fft_valid_out}, 32'd0);
        tick();
        chk("r030_lat2", {31'd0, fft_valid_out}, 32'd0);
        tick();
        chk("r030_lat3", {31'd0, fft_valid_out}, 32'd1);
        stream_check(f30, 1'b0, "r030");
        chk("r030_ovr", {31'd0, overrun_out}, 32'd0);

        // Ramp 1..12: second frame triggered by the hop
        restart();
        for (int i = 1; i <= N; i++) send(16'(i));
        stream_check(f31a, 1'b0, "r031a");
        for (int i = N + 1; i <= N + H; i++) send(16'(i));
        stream_check(f31b, 1'b0, "r031b");

        // Negative input, floor rounding
        restart();
        for (int i = 0; i < N; i++) send(16'hFF9B);
        stream_check(f32, 1'b0, "r032");

        // Random backpressure
        restart();
        for (int i = 0; i < N; i++) send(16'd100);
        stream_check(f30, 1'b1, "r033");

        // Long stall: one pending frame kept, later triggers dropped
        restart();
        fft_ready_in = 1'b0;
        for (int i = 0; i < N; i++) send(16'd100);
        for (int i = 0; i < H; i++) send(16'd1);
        chk("r034_pend_no_ovr", {31'd0, overrun_out}, 32'd0);
        for (int i = 0; i < H; i++) send(16'd2);
        chk("r034_ovr_set", {31'd0, overrun_out}, 32'd1);
        for (int i = 0; i < 7*H; i++) send(16'd3);
        chk("r034_ovr_hold", {31'd0, overrun_out}, 32'd1);
        fft_ready_in = 1'b1;
        beats = 0; lasts = 0; lastpos_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (fft_valid_out) begin
                if (fft_last_out) begin
                    lasts++;
                    if (beats % N != N-1) lastpos_ok = 1'b0;
                end
                beats++;
            end
            tick();
        end
        chk("r034_beats", beats, 2*N);
        chk("r034_lasts", lasts, 2);
        chk("r034_lastpos", {31'd0, lastpos_ok}, 32'd1);
        chk("r034_ovr_end", {31'd0, overrun_out}, 32'd1);

        // Reset in the middle of a frame
        restart();
        for (int i = 0; i < N; i++) send(16'd100);
        for (int i = 0; i < 6; i++) tick();
        chk("r035_b3", fft_data_out, 32'd75);
        rst_in = 1'b0;
        #1;
        chk("r035_valid", {31'd0, fft_valid_out}, 32'd0);
        chk("r035_last", {31'd0, fft_last_out}, 32'd0);
        chk("r035_data", fft_data_out, 32'd0);
        chk("r035_ovr", {31'd0, overrun_out}, 32'd0);
        tick();
        rst_in = 1'b1;
        seen = 0;
        for (int i = 0; i < N-1; i++) begin
            send(16'd100);
            if (fft_valid_out) seen++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fft_valid_out) seen++;
        end
        chk("r035_quiet", seen, 0);
        send(16'd100);
        stream_check(f30, 1'b0, "r035_new");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
